// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for the gpu_core write-combining burst engine.
package gpu_mem_pkg;
  localparam int BURST_MAX_DEF    = 8;
  localparam int BC_W_DEF         = 4;
  localparam int IDLE_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {EMPTY, FILLING, CLOSED} buf_state_t;
  typedef enum logic {IDLE, BURST} drain_state_t;
endpackage

// File: rtl/gpu_burst_writer_if.sv
// Bus bundle of the burst writer: gpu_core write side plus SDRAM burst side.
// master = gpu_core / SDRAM environment, slave = the burst writer itself.
interface gpu_burst_writer_if #(parameter int BC_W = 4);
  logic [31:0]     s_address;
  logic            s_write;
  logic [31:0]     s_write_data;
  logic            s_wait_request;
  logic            flush;
  logic            busy;
  logic [31:0]     m_address;
  logic            m_write;
  logic [31:0]     m_write_data;
  logic [BC_W-1:0] m_burstcount;
  logic            m_wait_request;

  modport slave (
    input  s_address, s_write, s_write_data, flush, m_wait_request,
    output s_wait_request, busy, m_address, m_write, m_write_data, m_burstcount
  );

  modport master (
    output s_address, s_write, s_write_data, flush, m_wait_request,
    input  s_wait_request, busy, m_address, m_write, m_write_data, m_burstcount
  );
endinterface

// File: rtl/gpu_line_buffer.sv
// One line buffer: gathers up to BURST_MAX consecutive words, then is held
// CLOSED until the drain side releases it.
module gpu_line_buffer
  import gpu_mem_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int BC_W      = BC_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_i,
  input  logic [29:0]                  wr_addr_i,
  input  logic [31:0]                  wr_data_i,
  input  logic                         close_i,
  input  logic                         release_i,
  input  logic [$clog2(BURST_MAX)-1:0] rd_idx_i,
  output buf_state_t                   state_o,
  output logic [31:0]                  base_o,
  output logic [BC_W-1:0]              count_o,
  output logic [31:0]                  rd_data_o
);
  localparam int AW = $clog2(BURST_MAX);

  logic [31:0]     mem_q [BURST_MAX];
  buf_state_t      state_q, state_d;
  logic [29:0]     base_q, base_d;
  logic [BC_W-1:0] count_q, count_d;
  logic [AW-1:0]   wr_idx;

  assign wr_idx = (state_q == EMPTY) ? '0 : count_q[AW-1:0];

  // A write that coincides with close lands before the buffer seals.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    if (wr_i) begin
      if (state_q == EMPTY) begin
        base_d  = wr_addr_i;
        count_d = BC_W'(1);
        state_d = FILLING;
      end else begin
        count_d = count_q + BC_W'(1);
      end
    end
    if (close_i) state_d = CLOSED;
    if (release_i) begin
      state_d = EMPTY;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      base_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[wr_idx] <= wr_data_i;
  end

  assign state_o   = state_q;
  assign base_o    = {base_q, 2'b00};
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/gpu_burst_writer.sv
// Write-combining burst engine: ping-pong line buffers filled from gpu_core,
// each drained to SDRAM as a single Avalon-MM burst.
//   state | meaning
//   IDLE  | no burst on the bus; picks the oldest CLOSED buffer
//   BURST | presenting beats of drain_sel until the last one is taken
module gpu_burst_writer
  import gpu_mem_pkg::*;
#(
  parameter int BURST_MAX    = BURST_MAX_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int BC_W         = BC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gpu_burst_writer_if.slave bus
);
  localparam int AW = $clog2(BURST_MAX);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  buf_state_t      st      [2];
  logic [31:0]     base    [2];
  logic [BC_W-1:0] cnt     [2];
  logic [31:0]     rd_data [2];
  logic [1:0]      buf_wr, buf_close, buf_rel;
  logic [AW-1:0]   rd_idx;

  logic            fill_sel_q, fill_sel_d, osel, tgt;
  logic [IW-1:0]   idle_q, idle_d;
  logic            consec, to_other, accept, wait_req, full, idle_done;
  logic            unused_addr_bits;

  drain_state_t    dstate_q;
  logic            drain_sel_q, m_write_q;
  logic [AW-1:0]   beat_q;
  logic [31:0]     m_addr_q, m_data_q;
  logic [BC_W-1:0] m_bc_q;
  logic            pick_valid, pick_sel, last_beat;

  for (genvar g = 0; g < 2; g++) begin : g_buf
    gpu_line_buffer #(.BURST_MAX(BURST_MAX), .BC_W(BC_W)) u_buf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_i      (buf_wr[g]),
      .wr_addr_i (bus.s_address[31:2]),
      .wr_data_i (bus.s_write_data),
      .close_i   (buf_close[g]),
      .release_i (buf_rel[g]),
      .rd_idx_i  (rd_idx),
      .state_o   (st[g]),
      .base_o    (base[g]),
      .count_o   (cnt[g]),
      .rd_data_o (rd_data[g])
    );
  end

  assign unused_addr_bits = ^bus.s_address[1:0];
  assign osel = ~fill_sel_q;

  // A word at the start of an aligned block never extends the previous burst.
  assign consec = (st[fill_sel_q] == FILLING)
               && (bus.s_address[AW+1:2] != '0)
               && (bus.s_address[31:2] == base[fill_sel_q][31:2] + 30'(cnt[fill_sel_q]));

  always_comb begin
    if (st[fill_sel_q] == FILLING && consec) wait_req = 1'b0;
    else if (st[fill_sel_q] == EMPTY)        wait_req = 1'b0;
    else if (st[osel] == EMPTY)              wait_req = 1'b0;
    else                                     wait_req = 1'b1;
  end

  assign bus.s_wait_request = rst_i | wait_req;
  assign accept    = bus.s_write & ~bus.s_wait_request;
  assign to_other  = !consec && (st[fill_sel_q] != EMPTY);
  assign tgt       = to_other ? osel : fill_sel_q;
  assign full      = (st[tgt] == FILLING) && (cnt[tgt] == BC_W'(BURST_MAX - 1));
  assign idle_done = (idle_q == '0);

  always_comb begin
    buf_wr     = '0;
    buf_close  = '0;
    fill_sel_d = fill_sel_q;
    if (accept) begin
      buf_wr[tgt] = 1'b1;
      if (to_other) begin
        fill_sel_d = osel;
        if (st[fill_sel_q] == FILLING) buf_close[fill_sel_q] = 1'b1;
      end
      if (full || bus.flush) buf_close[tgt] = 1'b1;
    end else if (st[fill_sel_q] == FILLING && (bus.flush || idle_done)) begin
      buf_close[fill_sel_q] = 1'b1;
    end
    if (accept || (buf_close != '0) || st[fill_sel_q] != FILLING) idle_d = IW'(IDLE_TIMEOUT);
    else                                                          idle_d = idle_q - IW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_sel_q <= 1'b0;
      idle_q     <= IW'(IDLE_TIMEOUT);
    end else begin
      fill_sel_q <= fill_sel_d;
      idle_q     <= idle_d;
    end
  end

  // Only the fill buffer can close, so when both are CLOSED the older is osel.
  assign pick_valid = (st[0] == CLOSED) || (st[1] == CLOSED);
  assign pick_sel   = (st[osel] == CLOSED) ? osel : fill_sel_q;
  assign rd_idx     = (dstate_q == BURST) ? beat_q + AW'(1) : '0;
  assign last_beat  = (BC_W'(beat_q) + BC_W'(1)) == m_bc_q;

  always_comb begin
    buf_rel = '0;
    if (dstate_q == BURST && !bus.m_wait_request && last_beat) buf_rel[drain_sel_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dstate_q    <= IDLE;
      drain_sel_q <= 1'b0;
      beat_q      <= '0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_bc_q      <= '0;
      m_data_q    <= '0;
    end else begin
      case (dstate_q)
        IDLE: if (pick_valid) begin
          dstate_q    <= BURST;
          drain_sel_q <= pick_sel;
          beat_q      <= '0;
          m_write_q   <= 1'b1;
          m_addr_q    <= base[pick_sel];
          m_bc_q      <= cnt[pick_sel];
          m_data_q    <= rd_data[pick_sel];
        end
        BURST: if (!bus.m_wait_request) begin
          if (last_beat) begin
            dstate_q  <= IDLE;
            m_write_q <= 1'b0;
          end else begin
            beat_q   <= beat_q + AW'(1);
            m_data_q <= rd_data[drain_sel_q];
          end
        end
        default: dstate_q <= IDLE;
      endcase
    end
  end

  assign bus.m_write      = m_write_q;
  assign bus.m_address    = m_addr_q;
  assign bus.m_burstcount = m_bc_q;
  assign bus.m_write_data = m_data_q;
  assign bus.busy         = (st[0] != EMPTY) || (st[1] != EMPTY) || (dstate_q == BURST);
endmodule

// File: tb/tb_gpu_burst_writer.sv
// Scoreboard bench for gpu_burst_writer: directed writes push expected beats,
// a negedge monitor pops and compares every beat the DUT hands to SDRAM.
module tb_gpu_burst_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpu_burst_writer_if #(.BC_W(4)) bus ();

  gpu_burst_writer #(.BURST_MAX(8), .IDLE_TIMEOUT(16), .BC_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  bc;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  int          beats_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_bc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic [31:0] a, input logic [3:0] bc, input logic [31:0] d);
    beat_t b;
    b.addr = a;
    b.bc   = bc;
    b.data = d;
    exp_q.push_back(b);
  endfunction

  // Monitor: a beat is taken on the next posedge when m_write && !m_wait_request.
  initial forever begin
    @(negedge clk);
    if (bus.m_write) begin
      if (prev_stall) begin
        chk("stall_addr_stable", bus.m_address, p_addr);
        chk("stall_bc_stable", 32'(bus.m_burstcount), 32'(p_bc));
        chk("stall_data_stable", bus.m_write_data, p_data);
      end
      if (!bus.m_wait_request) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %h data %h, required no beat", bus.m_address, bus.m_write_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_addr", bus.m_address, mon_e.addr);
          chk("beat_burstcount", 32'(bus.m_burstcount), 32'(mon_e.bc));
          chk("beat_data", bus.m_write_data, mon_e.data);
        end
      end
      prev_stall = bus.m_wait_request;
      p_addr     = bus.m_address;
      p_bc       = bus.m_burstcount;
      p_data     = bus.m_write_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Single write; returns how many cycles s_wait_request held it off.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int waited);
    waited = 0;
    bus.s_address    = a;
    bus.s_write_data = d;
    bus.s_write      = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.s_wait_request) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("FAIL write_accept_timeout: addr %h still stalled after %0d cycles, required acceptance", a, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_write = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || exp_q.size() != 0) && n < 300);
    chk({nm, "_drained_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_drained_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int w, n, b0;

  initial begin
    bus.s_address      = '0;
    bus.s_write        = 1'b0;
    bus.s_write_data   = '0;
    bus.flush          = 1'b0;
    bus.m_wait_request = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_s_wait_request", 32'(bus.s_wait_request), 32'd1);
    chk("rst_m_write", 32'(bus.m_write), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_m_address", bus.m_address, 32'd0);
    chk("rst_m_burstcount", 32'(bus.m_burstcount), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_s_wait_request", 32'(bus.s_wait_request), 32'd0);

    // 1: full 8-word line
    for (int i = 0; i < 8; i++) push(32'h1000, 4'd8, 32'hA000_0000 + i);
    for (int i = 0; i < 8; i++) begin
      wr(32'h1000 + 4 * i, 32'hA000_0000 + i, w);
      chk("t1_no_wait", 32'(w), 32'd0);
    end
    wait_idle("t1");

    // 2a: partial line closed by idle timeout
    push(32'h2000, 4'd2, 32'hB000_0000);
    push(32'h2000, 4'd2, 32'hB000_0001);
    wr(32'h2000, 32'hB000_0000, w);
    wr(32'h2004, 32'hB000_0001, w);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m_write && n < 60);
    checks++;
    if (n < 17 || n > 21) begin
      errors++;
      $display("FAIL t2_timeout_latency: got %0d cycles to m_write, required 17..21", n);
    end
    wait_idle("t2a");

    // 2b: same partial line closed early by flush
    push(32'h2000, 4'd2, 32'hB100_0000);
    push(32'h2000, 4'd2, 32'hB100_0001);
    wr(32'h2000, 32'hB100_0000, w);
    wr(32'h2004, 32'hB100_0001, w);
    repeat (2) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m_write && n < 60);
    checks++;
    if (n < 1 || n > 3) begin
      errors++;
      $display("FAIL t2_flush_latency: got %0d cycles to m_write, required 1..3", n);
    end
    wait_idle("t2b");

    // 3: third non-consecutive write stalls behind a stalled burst
    bus.m_wait_request = 1'b1;
    push(32'h3000, 4'd1, 32'hC000_0000);
    push(32'h5000, 4'd1, 32'hC000_0001);
    push(32'h7000, 4'd1, 32'hC000_0002);
    wr(32'h3000, 32'hC000_0000, w);
    chk("t3_first_no_wait", 32'(w), 32'd0);
    wr(32'h5000, 32'hC000_0001, w);
    chk("t3_second_no_wait", 32'(w), 32'd0);
    fork
      wr(32'h7000, 32'hC000_0002, w);
      begin
        repeat (6) @(negedge clk);
        chk("t3_third_stalled", 32'(bus.s_wait_request), 32'd1);
        chk("t3_burst_presented", 32'(bus.m_write), 32'd1);
        chk("t3_burst_addr", bus.m_address, 32'h3000);
        @(posedge clk);
        #1 bus.m_wait_request = 1'b0;
      end
    join
    checks++;
    if (w < 6) begin
      errors++;
      $display("FAIL t3_third_wait_cycles: got %0d, required at least 6", w);
    end
    wait_idle("t3");

    // 4: block boundary splits consecutive addresses
    push(32'h401C, 4'd1, 32'hD000_0000);
    push(32'h4020, 4'd1, 32'hD000_0001);
    wr(32'h401C, 32'hD000_0000, w);
    wr(32'h4020, 32'hD000_0001, w);
    chk("t4_boundary_no_wait", 32'(w), 32'd0);
    wait_idle("t4");

    // 5: random SDRAM stalls during an 8-beat burst
    b0 = beats_seen;
    bus.m_wait_request = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h8000, 4'd8, 32'hE000_0000 + 3 * i);
    for (int i = 0; i < 8; i++) wr(32'h8000 + 4 * i, 32'hE000_0000 + 3 * i, w);
    n = 0;
    while (bus.busy && n < 400) begin
      @(posedge clk);
      #1 bus.m_wait_request = 1'($urandom_range(0, 1));
      n++;
    end
    bus.m_wait_request = 1'b0;
    chk("t5_beats_issued", 32'(beats_seen - b0), 32'd8);
    wait_idle("t5");

    // 6: reset while beat 3 of an 8-beat burst is on the bus
    for (int i = 0; i < 3; i++) push(32'h9000, 4'd8, 32'hF000_0000 + i);
    for (int i = 0; i < 8; i++) wr(32'h9000 + 4 * i, 32'hF000_0000 + i, w);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (exp_q.size() != 0 && n < 200);
    chk("t6_beat3_on_bus", 32'(bus.m_write), 32'd1);
    chk("t6_beat3_data", bus.m_write_data, 32'hF000_0003);
    rst = 1'b1;
    #1;
    chk("t6_m_write_drop", 32'(bus.m_write), 32'd0);
    chk("t6_busy_clear", 32'(bus.busy), 32'd0);
    chk("t6_s_wait_in_rst", 32'(bus.s_wait_request), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(32'h6000, 4'd1, 32'h1234_5678);
    wr(32'h6000, 32'h1234_5678, w);
    chk("t6_fresh_no_wait", 32'(w), 32'd0);
    wait_idle("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
